// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the ID-stage hazard scoreboard.
package cpu_pkg;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int NREG = 32;
    localparam int CNT_W = 2;
    localparam int PERF_W = 32;
    typedef logic [4:0] reg_idx_t;
endpackage

// File: rtl/id_hazard_scoreboard_if.sv
// id_hazard_scoreboard_if: ID issue, WB retire and scoreboard status signals.
interface id_hazard_scoreboard_if;
    logic id_valid;
    cpu_pkg::reg_idx_t id_src1;
    logic id_src1_en;
    cpu_pkg::reg_idx_t id_src2;
    logic id_src2_en;
    cpu_pkg::reg_idx_t id_dest;
    logic id_gr_we;
    logic exe_allowin;
    logic wb_we;
    cpu_pkg::reg_idx_t wb_waddr;
    logic id_ready_go;
    logic id_issue;
    logic sb_busy;
    logic [cpu_pkg::PERF_W-1:0] stall_cnt;
    logic sb_err;
    modport master(
        output id_valid, id_src1, id_src1_en, id_src2, id_src2_en, id_dest, id_gr_we,
               exe_allowin, wb_we, wb_waddr,
        input  id_ready_go, id_issue, sb_busy, stall_cnt, sb_err
    );
    modport slave(
        input  id_valid, id_src1, id_src1_en, id_src2, id_src2_en, id_dest, id_gr_we,
               exe_allowin, wb_we, wb_waddr,
        output id_ready_go, id_issue, sb_busy, stall_cnt, sb_err
    );
endinterface

// File: rtl/sb_counter.sv
// sb_counter: saturating pending-write counter for one architectural register.
module sb_counter import cpu_pkg::*; (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic zero,
    output logic err
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        zero = cnt_q == '0;
        err = (inc & ~dec & (&cnt_q)) | (dec & ~inc & zero);
        cnt_d = (err || inc == dec) ? cnt_q : inc ? cnt_q + 1'b1 : cnt_q - 1'b1;
    end
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/id_hazard_scoreboard.sv
// id_hazard_scoreboard: holds ID on RAW hazards against in-flight register writes.
module id_hazard_scoreboard import cpu_pkg::*; (
    input logic clk,
    input logic reset,
    id_hazard_scoreboard_if.slave sb
);
    logic [NREG-1:0] busy, err;
    logic [NREG-1:1] inc, dec;
    logic inc_en, dec_en, ready, issue;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic sb_err_q, sb_err_d;
    // r0 is never busy, so a read of r0 can never raise a hazard
    assign busy[0] = 1'b0;
    assign err[0] = 1'b0;
    for (genvar g = 1; g < NREG; g++) begin : g_cnt
        assign inc[g] = inc_en & (sb.id_dest == 5'(g));
        assign dec[g] = dec_en & (sb.wb_waddr == 5'(g));
        sb_counter u_cnt (
            .clk(clk), .reset(reset), .inc(inc[g]), .dec(dec[g]),
            .zero(), .err(err[g])
        );
        assign busy[g] = ~g_cnt[g].u_cnt.zero;
    end
    always_comb begin
        ready = ~((sb.id_src1_en & busy[sb.id_src1]) | (sb.id_src2_en & busy[sb.id_src2]));
        issue = sb.id_valid & ready & sb.exe_allowin;
        inc_en = issue & sb.id_gr_we & (sb.id_dest != REG_ZERO);
        dec_en = sb.wb_we & (sb.wb_waddr != REG_ZERO);
        stall_cnt_d = stall_cnt_q + PERF_W'(sb.id_valid & ~ready);
        sb_err_d = sb_err_q | (|err);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            sb_err_q <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            sb_err_q <= sb_err_d;
        end
    end
    assign sb.id_ready_go = ready;
    assign sb.id_issue = issue;
    assign sb.sb_busy = |busy;
    assign sb.stall_cnt = stall_cnt_q;
    assign sb.sb_err = sb_err_q;
endmodule

// File: doc/id_hazard_scoreboard.md
# id_hazard_scoreboard

Register-write scoreboard and issue controller for the ID stage of the five-stage LoongArch pipeline. It counts in-flight writes per architectural register between ID→EXE issue and WB retirement, and drives ID's `id_ready_go` so a dependent instruction holds in ID until its producer has written the register file. It replaces the constant `id_ready_go = 1` once the pipeline has back-to-back RAW dependences and no forwarding. It also keeps a stall-cycle performance counter and a sticky error flag.

## Interface
- `NREG`, 32: number of architectural registers; r0 is never tracked.
- `CNT_W`, 2: width of each pending-write counter; max in flight per register is 2^CNT_W−1 = 3.
- `PERF_W`, 32: stall counter width.

- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high; sampled on posedge `clk`.
- `id_valid` in 1: ID holds a valid instruction.
- `id_src1` in 5: first source register (rj).
- `id_src1_en` in 1: instruction reads `id_src1`.
- `id_src2` in 5: second source register (rk or rd).
- `id_src2_en` in 1: instruction reads `id_src2`.
- `id_dest` in 5: destination register.
- `id_gr_we` in 1: instruction writes `id_dest`.
- `exe_allowin` in 1: EXE can accept.
- `wb_we` in 1: WB writes the register file this cycle; already qualified by WB valid.
- `wb_waddr` in 5: WB write address.
- `id_ready_go` out 1: ID may leave this cycle.
- `id_issue` out 1: `id_valid & id_ready_go & exe_allowin`.
- `sb_busy` out 1: any counter non-zero.
- `stall_cnt` out PERF_W: cycles with `id_valid & ~id_ready_go`.
- `sb_err` out 1: sticky; set on counter overflow or underflow.

## Operation
- State: `cnt[1..NREG-1]`, each CNT_W bits. `stall_cnt` and `sb_err` are registers.
- Hazard on src1: `id_src1_en & (id_src1 != 0) & (cnt[id_src1] != 0)`. src2 uses the same rule.
- `id_ready_go = ~(hazard on src1 | hazard on src2)`. This is combinational from the current counters, with no bypass.
- A retiring write (`wb_we`) does not clear a hazard in the same cycle. The regfile write lands at the posedge, so ID reads the correct value in the following cycle.
- Increment: on `id_issue & id_gr_we & (id_dest != 0)`, `cnt[id_dest]` increases by 1.
- Decrement: on `wb_we & (wb_waddr != 0)`, `cnt[wb_waddr]` decreases by 1.
- Increment and decrement on the same register in the same cycle leave it unchanged. On different registers, both updates apply.
- Overflow (increment at 3 without a matching decrement) holds the counter at its value and sets `sb_err`. Underflow (decrement at 0) does the same.
- `id_valid=0` never stalls and never increments. Branch redirect does not touch the scoreboard: only instructions that were actually issued are counted.
- `stall_cnt` increments on `id_valid & ~id_ready_go` and wraps modulo 2^PERF_W.
- Writes to r0 and reads of r0 are ignored entirely.

## Timing
- Reset values: all `cnt` = 0, `stall_cnt` = 0, `sb_err` = 0. After reset, `id_ready_go` = 1 (a combinational consequence of zero counters), `sb_busy` = 0, `id_issue` = `id_valid & exe_allowin`.
- Reset asserted mid-operation clears all state at the next posedge, regardless of `id_issue` or `wb_we` in that cycle.
- Counter updates take effect at the posedge after the event.
- Minimum dependent spacing (producer issues at cycle t, passes EXE, MEM, then WB at t+3): consumer `id_ready_go` is 0 in cycles t+1 to t+3 and 1 at t+4.
- `id_ready_go` does not depend on `exe_allowin`, so there is no combinational loop with the ID/EXE handshake.

## Structure
- Shared package `cpu_pkg`: `REG_ZERO` = 5'd0, `NREG`, `CNT_W`.
- One sub-module, `sb_counter`: one saturating up/down counter with inc, dec, zero, and err outputs, instantiated NREG−1 times via generate.
- The top level holds the hazard compare, the issue logic, `stall_cnt`, and the `sb_err` OR-reduce.

## Test plan
- Reset: hold `reset`=1 for 2 cycles, then release with `id_valid`=1 reading r5 → `id_ready_go`=1, `stall_cnt`=0, `sb_err`=0.
- RAW stall: issue a write to r4 at t, with a consumer reading r4 in ID from t+1 and `wb_we` r4 at t+3 → `id_ready_go`=0 for cycles t+1 to t+3, 1 at t+4, `stall_cnt`=3.
- r0: issue a write to r0, then a consumer reads r0 → no stall, `sb_busy`=0.
- Simultaneous events: `cnt[7]`=1, then `id_issue` writing r7 and `wb_we` r7 in the same cycle → `cnt[7]` stays 1 and a reader of r7 stays stalled.
- Saturation: issue 4 writes to r9 with no WB → `cnt[9]`=3 and `sb_err`=1, sticky until reset. A separate case: `wb_we` r10 with `cnt[10]`=0 → `sb_err`=1.
- Reset mid-flight: with `cnt[3]`=2 and a stall in progress, pulse `reset` → the next cycle shows `cnt[3]`=0, `id_ready_go`=1, `stall_cnt`=0.
